// File: rtl/keypad_loader.sv
// Keypad front end for the countdown timer: synchronises and debounces a one-hot keypad,
// shifts accepted BCD digits into the timer and sequences start / cancel / completion.
module keypad_loader #(
  parameter int DEBOUNCE   = 4,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] keys,
  input  logic       start,
  input  logic       cancel,
  input  logic       zero,
  output logic [3:0] CNT_out,
  output logic       loadn,
  output logic       en,
  output logic       timer_clrn,
  output logic [1:0] ndigits,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0] DEB_LEN  = 8'(DEBOUNCE);
  localparam logic [1:0] MAX_ND   = 2'(MAX_DIGITS);

  // Input path registers
  logic [9:0] keys_s1_q, keys_s2_q, samp_last_q, deb_q, deb_prev_q, deb_d;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic       start_s1_q, start_s2_q, start_s3_q;
  logic       cancel_s1_q, cancel_s2_q, cancel_s3_q;

  // Control registers
  state_e     state_q, state_d;
  logic [3:0] cnt_out_q, cnt_out_d;
  logic       loadn_q, loadn_d;
  logic       timer_clrn_q, timer_clrn_d;
  logic [1:0] ndigits_q, ndigits_d;
  logic       nonzero_q, nonzero_d;
  logic       first_run_q, first_run_d;

  logic       press, start_rise, cancel_rise;
  logic [3:0] digit;

  // Equal-sample counter restarts at 1 on any change and saturates so it never wraps.
  always_comb begin
    if (keys_s2_q != samp_last_q) db_cnt_d = 8'd1;
    else if (db_cnt_q != 8'hFF)   db_cnt_d = db_cnt_q + 8'd1;
    else                          db_cnt_d = db_cnt_q;
    deb_d = (db_cnt_d >= DEB_LEN) ? keys_s2_q : deb_q;
  end

  // NOTE: always_comb blocks assign every output a default first so no path can infer a latch.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (deb_q[i]) digit = 4'(i);
    end
  end

  assign press = (deb_q != 10'd0) && ((deb_q & (deb_q - 10'd1)) == 10'd0) &&
                 (deb_prev_q == 10'd0);
  assign start_rise  = start_s2_q & ~start_s3_q;
  assign cancel_rise = cancel_s2_q & ~cancel_s3_q;

  always_comb begin
    state_d      = state_q;
    cnt_out_d    = cnt_out_q;
    loadn_d      = 1'b1;
    timer_clrn_d = 1'b1;
    ndigits_d    = ndigits_q;
    nonzero_d    = nonzero_q;
    first_run_d  = 1'b0;

    if (cancel_rise) begin
      state_d      = S_IDLE;
      timer_clrn_d = 1'b0;
      cnt_out_d    = 4'd0;
      ndigits_d    = 2'd0;
      nonzero_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ENTRY: begin
          if (state_q == S_ENTRY && start_rise && nonzero_q) begin
            state_d     = S_RUN;
            first_run_d = 1'b1;
          end else if (press && (state_q == S_IDLE || ndigits_q < MAX_ND)) begin
            state_d   = S_ENTRY;
            cnt_out_d = digit;
            loadn_d   = 1'b0;
            ndigits_d = ndigits_q + 2'd1;
            nonzero_d = nonzero_q | (digit != 4'd0);
          end
        end
        S_RUN: begin
          // The timer's zero flag may still be stale from the previous run on entry.
          if (zero && !first_run_q) state_d = S_DONE;
        end
        S_DONE: begin
          if (press) begin
            state_d   = S_IDLE;
            ndigits_d = 2'd0;
            nonzero_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the reset is synchronous, so clr is only examined inside the clocked block.
  always_ff @(posedge clk) begin
    if (clr) begin
      keys_s1_q    <= '0;
      keys_s2_q    <= '0;
      samp_last_q  <= '0;
      db_cnt_q     <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_s3_q   <= 1'b0;
      cancel_s1_q  <= 1'b0;
      cancel_s2_q  <= 1'b0;
      cancel_s3_q  <= 1'b0;
      state_q      <= S_IDLE;
      cnt_out_q    <= 4'd0;
      loadn_q      <= 1'b1;
      timer_clrn_q <= 1'b1;
      ndigits_q    <= 2'd0;
      nonzero_q    <= 1'b0;
      first_run_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values.
      keys_s1_q    <= keys;
      keys_s2_q    <= keys_s1_q;
      samp_last_q  <= keys_s2_q;
      db_cnt_q     <= db_cnt_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      start_s1_q   <= start;
      start_s2_q   <= start_s1_q;
      start_s3_q   <= start_s2_q;
      cancel_s1_q  <= cancel;
      cancel_s2_q  <= cancel_s1_q;
      cancel_s3_q  <= cancel_s2_q;
      state_q      <= state_d;
      cnt_out_q    <= cnt_out_d;
      loadn_q      <= loadn_d;
      timer_clrn_q <= timer_clrn_d;
      ndigits_q    <= ndigits_d;
      nonzero_q    <= nonzero_d;
      first_run_q  <= first_run_d;
    end
  end

  assign CNT_out    = cnt_out_q;
  assign loadn      = loadn_q;
  assign timer_clrn = timer_clrn_q;
  assign ndigits    = ndigits_q;
  assign en         = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_keypad_loader.sv
// Bench for keypad_loader: directed vector table, timing corner sequences and a random
// operation stream checked against a transaction-level model of the loader.
module tb_keypad_loader;

  localparam int D    = 4;
  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       clr, start, cancel, zero;
  logic [9:0] keys;
  logic [3:0] CNT_out;
  logic       loadn, en, timer_clrn, done;
  logic [1:0] ndigits;

  always #5 clk = ~clk;

  keypad_loader #(.DEBOUNCE(D), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .clr(clr), .keys(keys), .start(start), .cancel(cancel), .zero(zero),
    .CNT_out(CNT_out), .loadn(loadn), .en(en), .timer_clrn(timer_clrn),
    .ndigits(ndigits), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse monitor: running totals sampled just after each rising edge.
  int loadn_lows = 0, clrn_lows = 0, loadn_consec = 0;
  bit prev_low = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (loadn === 1'b0) begin
      loadn_lows++;
      if (prev_low) loadn_consec++;
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
    if (timer_clrn === 1'b0) clrn_lows++;
  end

  typedef enum {OP_KEY, OP_START, OP_CANCEL, OP_ZERO, OP_BOTH} op_e;

  typedef struct {
    op_e        op;
    logic [9:0] k;
    int         e_ld;
    int         e_cnt;
    int         e_nd;
    int         e_en;
    int         e_done;
    int         e_cl;
  } vec_t;

  task automatic run_op(input op_e op, input logic [9:0] k, input int hold,
                        output int ld, output int cl);
    int l0, c0;
    l0 = loadn_lows;
    c0 = clrn_lows;
    @(negedge clk);
    case (op)
      OP_KEY: begin
        keys = k;
        repeat (hold) @(negedge clk);
        keys = '0;
        repeat (D + 8) @(negedge clk);
      end
      OP_ZERO: begin
        zero = 1'b1;
        @(negedge clk);
        zero = 1'b0;
        repeat (4) @(negedge clk);
      end
      default: begin
        if (op != OP_CANCEL) start = 1'b1;
        if (op != OP_START) cancel = 1'b1;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        repeat (6) @(negedge clk);
      end
    endcase
    ld = loadn_lows - l0;
    cl = clrn_lows - c0;
  endtask

  task automatic check_state(input string tag, input int ld, input int cl, input int e_ld,
                             input int e_cnt, input int e_nd, input int e_en,
                             input int e_done, input int e_cl);
    check({tag, ".loadn_pulses"}, ld, e_ld);
    check({tag, ".CNT_out"}, 32'(CNT_out), e_cnt);
    check({tag, ".ndigits"}, 32'(ndigits), e_nd);
    check({tag, ".en"}, 32'(en), e_en);
    check({tag, ".done"}, 32'(done), e_done);
    check({tag, ".clrn_pulses"}, cl, e_cl);
  endtask

  // Transaction-level reference: digits entered as a list, mode as a plain integer.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_DONE = 3;
  int m_mode;
  int m_digits[$];
  int m_last;

  function automatic bit m_nonzero();
    foreach (m_digits[i]) if (m_digits[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_digits.delete();
    m_last = 0;
  endtask

  task automatic model_step(input op_e op, input logic [9:0] k, output int e_ld, output int e_cl);
    int d;
    e_ld = 0;
    e_cl = 0;
    case (op)
      OP_CANCEL, OP_BOTH: begin
        e_cl = 1;
        model_reset();
      end
      OP_START: if (m_mode == M_ENTRY && m_nonzero()) m_mode = M_RUN;
      OP_ZERO:  if (m_mode == M_RUN) m_mode = M_DONE;
      default: begin
        if ($countones(k) == 1) begin
          d = 0;
          for (int i = 0; i < 10; i++) if (k[i]) d = i;
          if (m_mode == M_IDLE || (m_mode == M_ENTRY && m_digits.size() < MAXD)) begin
            m_digits.push_back(d);
            m_last = d;
            e_ld   = 1;
            m_mode = M_ENTRY;
          end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
            m_digits.delete();
          end
        end
      end
    endcase
  endtask

  vec_t tbl[19];

  initial begin
    int ld, cl, e_ld, e_cl, first, cnt_at, en_hi, r;
    logic [9:0] k;
    logic e2, e3, c3, c4;
    op_e op;

    //            op          keys    ld cnt nd en dn cl
    tbl[0]  = '{OP_KEY,    10'h002, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{OP_KEY,    10'h004, 1, 2, 2, 0, 0, 0};
    tbl[2]  = '{OP_KEY,    10'h008, 1, 3, 3, 0, 0, 0};
    tbl[3]  = '{OP_KEY,    10'h020, 0, 3, 3, 0, 0, 0};
    tbl[4]  = '{OP_START,  10'h000, 0, 3, 3, 1, 0, 0};
    tbl[5]  = '{OP_KEY,    10'h080, 0, 3, 3, 1, 0, 0};
    tbl[6]  = '{OP_ZERO,   10'h000, 0, 3, 3, 0, 1, 0};
    tbl[7]  = '{OP_KEY,    10'h200, 0, 3, 0, 0, 0, 0};
    tbl[8]  = '{OP_KEY,    10'h014, 0, 3, 0, 0, 0, 0};
    tbl[9]  = '{OP_KEY,    10'h001, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{OP_KEY,    10'h001, 1, 0, 2, 0, 0, 0};
    tbl[11] = '{OP_START,  10'h000, 0, 0, 2, 0, 0, 0};
    tbl[12] = '{OP_CANCEL, 10'h000, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{OP_KEY,    10'h040, 1, 6, 1, 0, 0, 0};
    tbl[14] = '{OP_BOTH,   10'h000, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{OP_KEY,    10'h008, 1, 3, 1, 0, 0, 0};
    tbl[16] = '{OP_START,  10'h000, 0, 3, 1, 1, 0, 0};
    tbl[17] = '{OP_CANCEL, 10'h000, 0, 0, 0, 0, 0, 1};
    tbl[18] = '{OP_CANCEL, 10'h000, 0, 0, 0, 0, 0, 1};

    // Reset with random inputs held for two cycles.
    clr = 1'b1;
    keys = 10'($urandom);
    start = 1'($urandom);
    cancel = 1'($urandom);
    zero = 1'($urandom);
    repeat (2) begin
      @(negedge clk);
      keys = 10'($urandom);
      start = 1'($urandom);
      cancel = 1'($urandom);
      zero = 1'($urandom);
    end
    clr = 1'b0; keys = '0; start = 1'b0; cancel = 1'b0; zero = 1'b0;
    repeat (10) @(negedge clk);
    check("reset.loadn_lows", loadn_lows, 0);
    check("reset.clrn_lows", clrn_lows, 0);
    check("reset.loadn", 32'(loadn), 1);
    check("reset.timer_clrn", 32'(timer_clrn), 1);
    check_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      run_op(tbl[i].op, tbl[i].k, 10, ld, cl);
      check_state($sformatf("vec%0d", i), ld, cl, tbl[i].e_ld, tbl[i].e_cnt, tbl[i].e_nd,
                  tbl[i].e_en, tbl[i].e_done, tbl[i].e_cl);
    end

    // Key 7 bouncing every cycle, then held steady.
    first = loadn_lows;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      keys = (i % 2 == 0) ? 10'h080 : 10'h000;
    end
    run_op(OP_KEY, 10'h080, 12, ld, cl);
    check_state("bounce7", loadn_lows - first, cl, 1, 7, 1, 0, 0, 0);

    // Exact press latency for key 4.
    first = -1;
    cnt_at = -1;
    ld = loadn_lows;
    @(negedge clk);
    keys = 10'h010;
    for (int i = 1; i <= D + 6; i++) begin
      @(posedge clk);
      #1;
      if (loadn === 1'b0 && first < 0) begin
        first = i;
        cnt_at = 32'(CNT_out);
      end
    end
    @(negedge clk);
    keys = '0;
    repeat (D + 8) @(negedge clk);
    check("latency.edge", first, D + 3);
    check("latency.CNT_out", cnt_at, 4);
    check("latency.pulses", loadn_lows - ld, 1);
    check("latency.ndigits", 32'(ndigits), 2);

    // Start latency: en rises on the third edge after start.
    @(negedge clk);
    start = 1'b1;
    e2 = 1'b1;
    e3 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) e2 = en;
      if (i == 3) e3 = en;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("start_lat.edge2_en", 32'(e2), 0);
    check("start_lat.edge3_en", 32'(e3), 1);

    // Cancel in RUN: en falls and timer_clrn pulses on the same edge.
    ld = clrn_lows;
    @(negedge clk);
    cancel = 1'b1;
    e2 = 1'b0; e3 = 1'b1; c3 = 1'b1; c4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) e2 = en;
      if (i == 3) begin e3 = en; c3 = timer_clrn; end
      if (i == 4) c4 = timer_clrn;
    end
    @(negedge clk);
    cancel = 1'b0;
    repeat (6) @(negedge clk);
    check("cancel_run.edge2_en", 32'(e2), 1);
    check("cancel_run.edge3_en", 32'(e3), 0);
    check("cancel_run.edge3_clrn", 32'(c3), 0);
    check("cancel_run.edge4_clrn", 32'(c4), 1);
    check("cancel_run.pulses", clrn_lows - ld, 1);
    check("cancel_run.ndigits", 32'(ndigits), 0);

    // Reset while running.
    run_op(OP_KEY, 10'h002, 10, ld, cl);
    run_op(OP_START, 10'h000, 0, ld, cl);
    check("clr_run.pre_en", 32'(en), 1);
    ld = loadn_lows;
    cl = clrn_lows;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_run.en", 32'(en), 0);
    check("clr_run.ndigits", 32'(ndigits), 0);
    check("clr_run.CNT_out", 32'(CNT_out), 0);
    check("clr_run.loadn", 32'(loadn), 1);
    check("clr_run.timer_clrn", 32'(timer_clrn), 1);
    @(negedge clk);
    clr = 1'b0;
    run_op(OP_KEY, 10'h200, 10, ld, cl);
    check_state("clr_run.key9", ld, cl, 1, 9, 1, 0, 0, 0);

    // zero already high when the run starts: ignored for the first RUN cycle only.
    @(negedge clk);
    zero = 1'b1;
    start = 1'b1;
    en_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (en === 1'b1) en_hi++;
      if (i == 1) start = 1'b0;
    end
    check("zero_first.en_cycles", en_hi, 2);
    check("zero_first.done", 32'(done), 1);
    @(negedge clk);
    zero = 1'b0;

    // Random operation stream against the reference model.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      k = '0;
      if (r <= 4) begin
        op = OP_KEY;
        k[$urandom_range(0, 9)] = 1'b1;
        if (r == 4) k[$urandom_range(0, 9)] = 1'b1;
      end else if (r <= 6) op = OP_START;
      else if (r == 7) op = OP_CANCEL;
      else if (r == 8) op = OP_ZERO;
      else op = OP_BOTH;
      run_op(op, k, int'($urandom_range(D + 4, D + 10)), ld, cl);
      model_step(op, k, e_ld, e_cl);
      check_state($sformatf("rand%0d", n), ld, cl, e_ld, m_last, m_digits.size(),
                  int'(m_mode == M_RUN), int'(m_mode == M_DONE), e_cl);
    end

    check("loadn_back_to_back", loadn_consec, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
# keypad_loader

Keypad-side driver for the countdown timer's serial digit-load interface. It debounces a 10-key one-hot keypad, turns each accepted keypress into a single-cycle shift of one BCD digit into the timer (`CNT_out`/`loadn`), and sequences start, cancel and completion of the countdown through `en`, `timer_clrn` and the timer's `zero` flag. It sits between the keypad pins and the timer instance at the top level.

## Interface
- `DEBOUNCE`, default 4: consecutive identical raw samples required before the debounced key vector updates; range 1..255.
- `MAX_DIGITS`, default 3: digits accepted per entry (mins, sec_tens, sec_ones).
- `clk`  in  1  system clock, all logic on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `keys`  in  10  raw keypad, bit i high = digit i pressed; asynchronous to `clk`.
- `start`  in  1  start request, level, edge-detected internally.
- `cancel`  in  1  cancel request, level, edge-detected internally.
- `zero`  in  1  timer count-reached-zero flag.
- `CNT_out`  out  4  BCD digit to timer `CNT_in`; bit ordering identical to timer `CNT_in`.
- `loadn`  out  1  active-low shift strobe to timer; low exactly one cycle per accepted digit.
- `en`  out  1  timer count enable.
- `timer_clrn`  out  1  active-low clear to timer; one-cycle low pulse.
- `ndigits`  out  2  digits entered so far (0..MAX_DIGITS).
- `done`  out  1  high while in DONE.

## Operation
- Input path: `keys` → 2-flop synchronizer → debounce counter (reloads on any change; at DEBOUNCE equal samples copies into debounced vector) → press detector. `start`/`cancel` pass through a 2-flop synchronizer and rising-edge detector; they are not debounced.
- Accepted press: debounced vector goes from all-zero to exactly one bit set. Multi-bit vectors, and transitions from non-zero vectors, are ignored. Releases are never reported.
- The 4-bit digit is the index of the set bit, 0..9. There is no magnitude check; `sec_tens` range is owned by the timer.
- Each accepted press in IDLE or ENTRY registers `CNT_out` = digit, drives `loadn` = 0 for one cycle, and increments `ndigits`. A `nonzero` flag is set if the digit ≠ 0.
- State machine (4 states):
  - IDLE
    - Press → emit digit, go to ENTRY with `ndigits`=1.
    - `start` ignored.
    - `cancel` → `timer_clrn` pulse, stay in IDLE.
  - ENTRY
    - Press with `ndigits` < MAX_DIGITS → emit digit.
    - Press at MAX_DIGITS → ignored, no `loadn` pulse.
    - `start` with `nonzero`=1 → RUN, `en`=1.
    - `start` with `nonzero`=0 → ignored.
    - `cancel` → `timer_clrn` pulse, clear `ndigits` and `nonzero`, go to IDLE.
  - RUN
    - `en`=1; presses and `start` ignored.
    - `zero`=1 → DONE, `en`=0. `zero` is ignored in the first RUN cycle.
    - `cancel` → `en`=0, `timer_clrn` pulse, go to IDLE.
  - DONE
    - `done`=1.
    - Any accepted press → IDLE, clearing `ndigits` and `nonzero`; that press is consumed and not emitted.
    - `cancel` → `timer_clrn` pulse, go to IDLE.
    - `start` ignored.
- Priority within one cycle: `clr` > `cancel` > `start` > key press. When `start` is accepted, a simultaneous press is discarded.
- `CNT_out` holds the last emitted digit until the next emission, cancel, or reset, all of which update or clear it.

## Timing
- Reset values, 1 cycle after `clr` sampled high:
  - `CNT_out`=0, `loadn`=1, `en`=0, `timer_clrn`=1, `done`=0, `ndigits`=0.
  - State IDLE; synchronizers and debounced vector cleared.
- `clr` mid-operation: all outputs take their reset values on the next edge. Any pending `loadn` or `timer_clrn` pulse is dropped; `en` falls immediately.
- Press latency: a raw key stable from edge k gives `loadn` low during the cycle after edge k+DEBOUNCE+2, for exactly 1 cycle. `CNT_out` is valid in that same cycle.
- Back-to-back digits: minimum spacing is set by release plus re-press debounce, at least 2·DEBOUNCE cycles. `loadn` never stays low for 2 consecutive cycles.
- `start`/`cancel` to output: state and `en`/`timer_clrn` change 3 edges after the raw rising edge (2 synchronizer edges plus 1 registered decision).
- `zero` to `en`=0: 1 cycle, registered.
- `timer_clrn` low for exactly 1 cycle per cancel.

## Test plan
- Reset: assert `clr` 2 cycles with random inputs → all outputs at reset values; no `loadn` or `timer_clrn` pulse during or after.
- Entry and run, DEBOUNCE=4: press keys 1, 2, 3 in turn, each held 10 cycles with 10-cycle gaps → three single-cycle `loadn` lows, `CNT_out` = 1, 2, 3, `ndigits` = 3. Then pulse `start` → `en`=1 three edges later. Drive `zero`=1 → `en`=0 and `done`=1 one cycle later.
- Overflow and glitch:
  - Fourth press (key 5) after 3 digits → no `loadn`, `ndigits` stays 3.
  - Key 7 bouncing at a 2-cycle period for 20 cycles, then stable → exactly one `loadn` with `CNT_out`=7.
- Invalid inputs: keys 2 and 4 pressed together → no emission. Entry "0","0" then `start` → stays in ENTRY with `en`=0.
- Cancel paths: cancel in ENTRY → `timer_clrn` 1-cycle low, `ndigits`=0. Cancel in RUN → `en`=0 and `timer_clrn` pulse on the same edge. `start` and `cancel` rising together → cancel wins.
- Reset mid-run: `clr` while `en`=1 → `en`=0 next edge, state IDLE. A subsequent press of key 9 emits `CNT_out`=9 with `ndigits`=1.
